layer_output_serializer: RTL and testbench

- Sits directly downstream of one layer's bank of neuron instances and upstream of the next layer's neurons.
- Captures the parallel neuron results of a layer in a single cycle, when the neurons' one-cycle output_valid pulse arrives.
- Replays the captured results as a serial stream, one value per cycle, on the next layer's shared input/input_valid bus. Sample 0 goes first.
- Flags protocol faults: mismatched valid pulses, and a new layer result arriving while the previous one is still being replayed.

---
 rtl/layer_output_serializer.sv | 87 ++++++++
 tb/tb_layer_output_serializer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/layer_output_serializer.sv
// layer_output_serializer: captures a layer's parallel neuron outputs in one cycle and replays them serially
module layer_output_serializer #(
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = 16,
    parameter int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] neuron_data,
    input  logic [NUM_NEURONS-1:0]            neuron_valid,
    input  logic                              clear_err,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_valid,
    output logic                              out_last,
    output logic [IDX_W-1:0]                  out_index,
    output logic                              busy,
    output logic                              overrun,
    output logic                              valid_mismatch
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    state_t                state_q;
    logic [DATA_WIDTH-1:0] buf_q [NUM_NEURONS];
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  out_valid_q, out_last_q, overrun_q, mismatch_q;
    logic                  cap, accept, overrun_d, mismatch_d;

    // Decode capture acceptance, the next sample index and the sticky fault flags (set beats clear)
    always_comb begin
        cap        = neuron_valid[0];
        accept     = cap && (state_q == IDLE || out_last_q);
        idx_d      = idx_q + 1'b1;
        overrun_d  = (overrun_q && !clear_err) || (cap && state_q == SHIFT && !out_last_q);
        mismatch_d = (mismatch_q && !clear_err) || ((|neuron_valid) && !(&neuron_valid));
    end

    // Capture buffer is only loaded on an accepted capture; contents after reset do not matter
    always_ff @(posedge clk) begin
        if (accept)
            for (int i = 0; i < NUM_NEURONS; i++)
                buf_q[i] <= neuron_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Replay FSM with registered outputs; sample 0 is taken straight from the inputs so it appears one cycle after capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            overrun_q   <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            overrun_q  <= overrun_d;
            mismatch_q <= mismatch_d;
            if (accept) begin
                state_q     <= SHIFT;
                idx_q       <= '0;
                out_data_q  <= neuron_data[DATA_WIDTH-1:0];
                out_valid_q <= 1'b1;
                out_last_q  <= (LAST_IDX == '0);
            end else if (state_q == SHIFT && out_last_q) begin
                state_q     <= IDLE;
                idx_q       <= '0;
                out_data_q  <= '0;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else if (state_q == SHIFT) begin
                idx_q      <= idx_d;
                out_data_q <= buf_q[idx_d];
                out_last_q <= (idx_d == LAST_IDX);
            end
        end
    end

    assign out_data       = out_data_q;
    assign out_valid      = out_valid_q;
    assign out_last       = out_last_q;
    assign out_index      = idx_q;
    assign busy           = (state_q == SHIFT);
    assign overrun        = overrun_q;
    assign valid_mismatch = mismatch_q;
endmodule

// File: tb/tb_layer_output_serializer.sv
// tb_layer_output_serializer: directed checks of the serializer with 4 neurons and with a single neuron
module tb_layer_output_serializer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] nd_a = '0;
    logic [3:0]  nv_a = '0;
    logic [15:0] nd_b = '0;
    logic [0:0]  nv_b = '0;
    logic        clr = 1'b0;

    logic [15:0] od_a, od_b;
    logic        ov_a, ol_a, busy_a, ovr_a, mis_a;
    logic        ov_b, ol_b, busy_b, ovr_b, mis_b;
    logic [1:0]  oi_a;
    logic [0:0]  oi_b;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    layer_output_serializer #(.NUM_NEURONS(4), .DATA_WIDTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .neuron_data(nd_a), .neuron_valid(nv_a), .clear_err(clr),
        .out_data(od_a), .out_valid(ov_a), .out_last(ol_a), .out_index(oi_a),
        .busy(busy_a), .overrun(ovr_a), .valid_mismatch(mis_a)
    );

    layer_output_serializer #(.NUM_NEURONS(1), .DATA_WIDTH(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .neuron_data(nd_b), .neuron_valid(nv_b), .clear_err(clr),
        .out_data(od_b), .out_valid(ov_b), .out_last(ol_b), .out_index(oi_b),
        .busy(busy_b), .overrun(ovr_b), .valid_mismatch(mis_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // expects one sample of dut_a: valid, data, index, last, busy
    task automatic samp_a(input string tag, input logic [15:0] d, input logic [1:0] i, input logic l);
        chk({tag, " valid"}, ov_a, 1'b1);
        chk({tag, " data"}, od_a, d);
        chk({tag, " index"}, oi_a, i);
        chk({tag, " last"}, ol_a, l);
        chk({tag, " busy"}, busy_a, 1'b1);
    endtask

    task automatic idle_a(input string tag);
        chk({tag, " valid"}, ov_a, 1'b0);
        chk({tag, " busy"}, busy_a, 1'b0);
        chk({tag, " last"}, ol_a, 1'b0);
    endtask

    initial begin
        // reset state
        #1;
        chk("rst data", od_a, 16'h0);
        chk("rst valid", ov_a, 1'b0);
        chk("rst last", ol_a, 1'b0);
        chk("rst index", oi_a, 2'd0);
        chk("rst busy", busy_a, 1'b0);
        chk("rst overrun", ovr_a, 1'b0);
        chk("rst mismatch", mis_a, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: single capture and replay
        nd_a = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        nv_a = 4'hF;
        tick();
        nv_a = 4'h0;
        samp_a("t1 s0", 16'h1, 2'd0, 1'b0);
        tick(); samp_a("t1 s1", 16'h2, 2'd1, 1'b0);
        tick(); samp_a("t1 s2", 16'h3, 2'd2, 1'b0);
        tick(); samp_a("t1 s3", 16'h4, 2'd3, 1'b1);
        tick(); idle_a("t1 end");
        chk("t1 overrun", ovr_a, 1'b0);

        // 2: back-to-back capture on the last sample
        nv_a = 4'hF;
        tick();
        nv_a = 4'h0;
        samp_a("t2 a0", 16'h1, 2'd0, 1'b0);
        tick(); tick(); tick();
        samp_a("t2 a3", 16'h4, 2'd3, 1'b1);
        nd_a = {16'h0008, 16'h0007, 16'h0006, 16'h0005};
        nv_a = 4'hF;
        tick();
        nv_a = 4'h0;
        samp_a("t2 b0", 16'h5, 2'd0, 1'b0);
        chk("t2 overrun", ovr_a, 1'b0);
        tick(); samp_a("t2 b1", 16'h6, 2'd1, 1'b0);
        tick(); samp_a("t2 b2", 16'h7, 2'd2, 1'b0);
        tick(); samp_a("t2 b3", 16'h8, 2'd3, 1'b1);
        tick(); idle_a("t2 end");

        // 3: overrun while index=1
        nd_a = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        nv_a = 4'hF;
        tick();
        nv_a = 4'h0;
        tick();
        samp_a("t3 s1", 16'h2, 2'd1, 1'b0);
        nd_a = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
        nv_a = 4'hF;
        tick();
        nv_a = 4'h0;
        samp_a("t3 s2", 16'h3, 2'd2, 1'b0);
        chk("t3 overrun set", ovr_a, 1'b1);
        tick(); samp_a("t3 s3", 16'h4, 2'd3, 1'b1);
        tick(); idle_a("t3 end");
        chk("t3 overrun sticky", ovr_a, 1'b1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t3 overrun cleared", ovr_a, 1'b0);

        // 4: mismatched valids, capture follows bit 0
        nd_a = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
        nv_a = 4'b0111;
        tick();
        nv_a = 4'h0;
        samp_a("t4 s0", 16'h11, 2'd0, 1'b0);
        chk("t4 mismatch set", mis_a, 1'b1);
        tick(); samp_a("t4 s1", 16'h22, 2'd1, 1'b0);
        tick(); samp_a("t4 s2", 16'h33, 2'd2, 1'b0);
        tick(); samp_a("t4 s3", 16'h44, 2'd3, 1'b1);
        tick(); idle_a("t4 end");
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t4 mismatch cleared", mis_a, 1'b0);
        nv_a = 4'b1110;
        tick();
        nv_a = 4'h0;
        idle_a("t4 no capture");
        chk("t4 mismatch 1110", mis_a, 1'b1);
        chk("t4 no overrun", ovr_a, 1'b0);
        clr = 1'b1;
        nv_a = 4'b1110;
        tick();
        clr = 1'b0;
        nv_a = 4'h0;
        chk("t4 set beats clear", mis_a, 1'b1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t4 final clear", mis_a, 1'b0);

        // 5: reset mid-replay
        nd_a = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        nv_a = 4'hF;
        tick();
        nv_a = 4'h0;
        tick(); tick();
        samp_a("t5 s2", 16'h3, 2'd2, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("t5 rst valid", ov_a, 1'b0);
        chk("t5 rst data", od_a, 16'h0);
        chk("t5 rst index", oi_a, 2'd0);
        chk("t5 rst busy", busy_a, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        idle_a("t5 after rst");
        nv_a = 4'hF;
        tick();
        nv_a = 4'h0;
        samp_a("t5 fresh s0", 16'h1, 2'd0, 1'b0);
        tick(); samp_a("t5 fresh s1", 16'h2, 2'd1, 1'b0);
        tick(); tick(); tick();
        idle_a("t5 end");

        // 6: single neuron, capture every cycle
        nd_b = 16'd7;
        nv_b = 1'b1;
        tick();
        chk("t6 d7", od_b, 16'd7);
        chk("t6 v7", ov_b, 1'b1);
        chk("t6 l7", ol_b, 1'b1);
        nd_b = 16'd8;
        tick();
        chk("t6 d8", od_b, 16'd8);
        chk("t6 l8", ol_b, 1'b1);
        chk("t6 v8", ov_b, 1'b1);
        nd_b = 16'd9;
        tick();
        nv_b = 1'b0;
        chk("t6 d9", od_b, 16'd9);
        chk("t6 l9", ol_b, 1'b1);
        chk("t6 i9", oi_b, 1'b0);
        chk("t6 overrun", ovr_b, 1'b0);
        tick();
        chk("t6 end valid", ov_b, 1'b0);
        chk("t6 end busy", busy_b, 1'b0);
        chk("t6 end overrun", ovr_b, 1'b0);
        chk("t6 mismatch", mis_b, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
